// File: rtl/pipe_credit_rx.sv
// Credit-returning receive FIFO at the sink of a fixed-latency, no-back-pressure pipeline.
// Optional sticky overflow flag is enabled by defining PIPE_CREDIT_RX_ERR_EN.
module pipe_credit_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic                       credit_ret,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       init_done
`ifdef PIPE_CREDIT_RX_ERR_EN
  ,
  output logic                       err_overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    fill_r;
  logic [CW-1:0]    pend_r;
  logic [CW-1:0]    init_cnt_r;
  state_t           state_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             credit_ret_r;
  logic             init_done_r;

  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             overflow_s;
  logic [AW-1:0]    rd_next_s;
  logic [AW-1:0]    wr_next_s;
  logic [CW-1:0]    fill_next_s;
  logic [CW:0]      pe_s;
  logic [WIDTH-1:0] head_next_s;

  // Push/pop decisions, next pointers, next occupancy and the next head word.
  always_comb begin
    full_s      = (fill_r == CW'(DEPTH));
    pop_s       = out_valid_r && out_ready;
    push_s      = in_valid && (!full_s || pop_s);
    overflow_s  = in_valid && full_s && !pop_s;
    rd_next_s   = pop_s  ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    wr_next_s   = push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
    pe_s        = {1'b0, pend_r} + {{CW{1'b0}}, pop_s};
    fill_next_s = fill_r;
    case ({push_s, pop_s})
      2'b10:   fill_next_s = fill_r + CW'(1);
      2'b01:   fill_next_s = fill_r - CW'(1);
      default: fill_next_s = fill_r;
    endcase
    // The word being written lands at the head when the FIFO is (or becomes) empty.
    if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = in_data;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Storage array; contents are only observed through the registered head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers, occupancy and the registered head presentation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      fill_r      <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r    <= wr_next_s;
      rd_ptr_r    <= rd_next_s;
      fill_r      <= fill_next_s;
      out_valid_r <= (fill_next_s != {CW{1'b0}});
      if (fill_next_s != {CW{1'b0}}) begin
        out_data_r <= head_next_s;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  // Credit engine: every pop adds a pending credit, at most one is returned per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r       <= CW'(DEPTH);
      credit_ret_r <= 1'b0;
    end else if (pe_s != {(CW+1){1'b0}}) begin
      pend_r       <= CW'(pe_s - {{CW{1'b0}}, 1'b1});
      credit_ret_r <= 1'b1;
    end else begin
      pend_r       <= {CW{1'b0}};
      credit_ret_r <= 1'b0;
    end
  end

  // INIT lasts until the DEPTH-th initial credit goes out; RUN holds until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= {CW{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (pe_s != {(CW+1){1'b0}}) begin
            if (init_cnt_r == CW'(DEPTH - 1)) begin
              state_r     <= ST_RUN;
              init_done_r <= 1'b1;
            end else begin
              init_cnt_r  <= init_cnt_r + CW'(1);
              init_done_r <= 1'b0;
            end
          end else begin
            init_done_r <= 1'b0;
          end
        end
        ST_RUN: begin
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          init_cnt_r  <= {CW{1'b0}};
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CREDIT_RX_ERR_EN
  logic err_overflow_r;

  // Sticky record of any dropped word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_overflow_r <= 1'b0;
    end else if (overflow_s) begin
      err_overflow_r <= 1'b1;
    end else begin
      err_overflow_r <= err_overflow_r;
    end
  end

  assign err_overflow = err_overflow_r;
`else
  logic unused_overflow_s;
  assign unused_overflow_s = overflow_s;
`endif

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign credit_ret = credit_ret_r;
  assign fill       = fill_r;
  assign init_done  = init_done_r;

endmodule

// File: tb/tb_pipe_credit_rx.sv
// Self-checking bench for pipe_credit_rx: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.
module tb_pipe_credit_rx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             credit_ret;
  logic [CW-1:0]    fill;
  logic             init_done;
`ifdef PIPE_CREDIT_RX_ERR_EN
  logic             err_overflow;
`endif

  pipe_credit_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .credit_ret(credit_ret), .fill(fill), .init_done(init_done)
`ifdef PIPE_CREDIT_RX_ERR_EN
    , .err_overflow(err_overflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq[$];
  int               m_pend;
  int               m_init_cnt;
  bit               m_init_done;
  bit               m_credit;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  bit               m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model with the inputs present at the edge, compare.
  task automatic tick();
    bit pop;
    bit push;
    int pe;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mq.delete();
      m_pend = DEPTH; m_init_cnt = 0; m_init_done = 0;
      m_credit = 0; m_valid = 0; m_data = '0; m_err = 0;
    end else begin
      pop  = (mq.size() > 0) && out_ready;
      push = in_valid && ((mq.size() < DEPTH) || pop);
      if (in_valid && !push) m_err = 1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(in_data);
      pe = m_pend + (pop ? 1 : 0);
      m_credit = (pe > 0);
      m_pend = (pe > 0) ? pe - 1 : 0;
      if (m_credit && !m_init_done) begin
        m_init_cnt++;
        if (m_init_cnt == DEPTH) m_init_done = 1;
      end
      m_valid = (mq.size() > 0);
      if (m_valid) m_data = mq[0];
    end
    check("model_out_valid", 32'(out_valid), 32'(m_valid));
    check("model_out_data", 32'(out_data), 32'(m_data));
    check("model_fill", 32'(fill), 32'(mq.size()));
    check("model_credit_ret", 32'(credit_ret), 32'(m_credit));
    check("model_init_done", 32'(init_done), 32'(m_init_done));
`ifdef PIPE_CREDIT_RX_ERR_EN
    check("model_err_overflow", 32'(err_overflow), 32'(m_err));
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_fill", 32'(fill), 32'd0);
    check("reset_credit", 32'(credit_ret), 32'd0);

    // Reset release: credits in cycles 1..4, init_done from cycle 4.
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("init_credit", 32'(credit_ret), 32'((i <= DEPTH) ? 1 : 0));
      check("init_done", 32'(init_done), 32'((i >= DEPTH) ? 1 : 0));
    end
    check("init_fill", 32'(fill), 32'd0);

    // Single word with ready high.
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hA5);
    tick();
    check("single_credit", 32'(credit_ret), 32'd1);
    check("single_empty", 32'(out_valid), 32'd0);
    tick();
    check("single_credit_end", 32'(credit_ret), 32'd0);

    // Fill and hold.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("hold_fill", 32'(fill), 32'd4);
    check("hold_data", 32'(out_data), 32'h10);
    check("hold_no_credit", 32'(credit_ret), 32'd0);

    // Full with simultaneous push and pop.
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("full_pp_fill", 32'(fill), 32'd4);
    check("full_pp_credit", 32'(credit_ret), 32'd1);
    check("full_pp_head", 32'(out_data), 32'h11);
    tick();
    check("full_pp_credit_once", 32'(credit_ret), 32'd0);

    // Overflow: word dropped.
    in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("ovf_fill", 32'(fill), 32'd4);
`ifdef PIPE_CREDIT_RX_ERR_EN
    check("ovf_err", 32'(err_overflow), 32'd1);
`endif
    tick();

    // Drain: contents unchanged and one credit per consecutive cycle.
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      logic [WIDTH-1:0] exp_word;
      exp_word = (i == 3) ? 8'h77 : 8'(8'h11 + i);
      check("drain_data", 32'(out_data), 32'(exp_word));
      tick();
      check("drain_credit", 32'(credit_ret), 32'd1);
    end
    out_ready = 1'b0;
    tick();
    check("drain_credit_stop", 32'(credit_ret), 32'd0);
`ifdef PIPE_CREDIT_RX_ERR_EN
    check("ovf_err_sticky", 32'(err_overflow), 32'd1);
`endif

    // Reset mid-drain, then initial credit sequence repeats.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_fill", 32'(fill), 32'd0);
    check("midrst_credit", 32'(credit_ret), 32'd0);
    check("midrst_init", 32'(init_done), 32'd0);
    rst_n = 1'b1; out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("rerun_credit", 32'(credit_ret), 32'((i <= DEPTH) ? 1 : 0));
      check("rerun_init", 32'(init_done), 32'((i >= DEPTH) ? 1 : 0));
    end

    // Random traffic with occasional resets, compared against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = 8'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_credit_rx.md
# pipe_credit_rx

Receiving end of a fixed-latency registered data pipeline with no back-pressure on the pipeline wires. It captures each valid word arriving from the last pipeline flop into a small FIFO and presents the words downstream with valid/ready. It returns one credit pulse per freed entry so the sender's credit counter throttles the pipeline. It sits at the sink of register-to-register paths, mirroring the sender-side credit counter.

## Interface
- `WIDTH`, default 8: data word width.
- `DEPTH`, default 4: FIFO entries. Must be a power of two and at least 2. Equals the total credits issued.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `in_valid` input, 1 bit: a word is present on `in_data` this cycle.
- `in_data` input, `WIDTH` bits: incoming word.
- `out_valid` output, 1 bit: FIFO head is valid.
- `out_data` output, `WIDTH` bits: FIFO head word.
- `out_ready` input, 1 bit: downstream accepts the head.
- `credit_ret` output, 1 bit: one-cycle pulse that returns one credit to the sender.
- `fill` output, clog2(`DEPTH`+1) bits: current FIFO occupancy.
- `init_done` output, 1 bit: high once all `DEPTH` initial credits have been issued.
- `err_overflow` output, 1 bit: sticky overflow flag. Present only with `PIPE_CREDIT_RX_ERR_EN`.

## Operation
- **Push:** `in_valid` && (not full || pop this cycle). Writes at the tail.
- **Pop:** `out_valid` && `out_ready`. Advances the head.
- **Simultaneous push and pop:**
  - When full, both take effect and `fill` is unchanged.
  - When empty, no pop is possible; the push is accepted and the word appears the next cycle (no combinational bypass).
- **Overflow:** `in_valid` && full && no pop. The word is dropped and FIFO contents are unchanged.
- **Credit engine:**
  - Pending counter `pend`, width clog2(`DEPTH`+1); reset value `DEPTH`.
  - Each cycle, `pe` = `pend` + pop.
  - If `pe` > 0: `credit_ret` <= 1 and `pend` <= `pe` − 1.
  - Otherwise: `credit_ret` <= 0 and `pend` <= 0.
  - At most one credit per cycle. Credits are conserved: credits returned plus words buffered plus `pend` always equals `DEPTH`.
- **State machine:**
  - INIT: entered on reset; `init_done` = 0.
  - INIT → RUN on the edge where the `DEPTH`-th initial credit is issued.
  - RUN is held until reset; `init_done` = 1.
  - Pushes and pops are legal in both states. Pops during INIT add to `pend` and extend the credit stream.
- **Pointers:** read and write pointers are clog2(`DEPTH`) bits and wrap modulo `DEPTH`. `fill` is tracked separately.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0, `credit_ret` = 0, `fill` = 0, `init_done` = 0, `err_overflow` = 0.
  - Pointers 0, `pend` = `DEPTH`, state INIT.
- **Reset mid-operation:** all buffered words and pending credits are discarded, and the credit stream restarts from `DEPTH`.
- **Initial credits:** `credit_ret` is high in cycles 1 through `DEPTH` after the first cycle with `rst_n` = 1. `init_done` rises in cycle `DEPTH`, the same cycle as the last initial credit.
- **Data latency:** a push in cycle t gives `out_valid` = 1 in cycle t+1 if the FIFO was empty.
- **Outputs:** `out_data` is stable while `out_valid` && !`out_ready`. `fill` updates one cycle after the push or pop.
- **Credit latency:** a pop in cycle t with `pend` = 0 gives `credit_ret` = 1 in cycle t+1. With backlog, credits drain at one per cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`PIPE_CREDIT_RX_ERR_EN` defined:**
  - The `err_overflow` port exists.
  - It is set in the cycle after any overflow and held until `rst_n` = 0.
- **Not defined:**
  - The port is absent.
  - Overflow words are silently dropped.
  - All other behaviour is identical.

## Test plan
1. **Reset release:** `DEPTH`=4, idle after reset → `credit_ret` high in cycles 1–4 and low afterwards; `init_done` = 1 from cycle 4; `fill` = 0.
2. **Single word:** push 0xA5 in cycle 10 with `out_ready` = 1 → `out_valid` = 1 and `out_data` = 0xA5 in cycle 11; pop in cycle 11; `credit_ret` pulse in cycle 12.
3. **Fill and hold:** push 4 words with `out_ready` = 0 → `fill` = 4, `out_data` holds the first word, and no `credit_ret` pulses.
4. **Full with simultaneous traffic:** FIFO full, then push and pop in the same cycle → word accepted, `fill` stays 4, one `credit_ret` follows.
5. **Overflow:** FIFO full, push with `out_ready` = 0 →
   - Word dropped; `fill` = 4.
   - Contents unchanged after draining.
   - With `PIPE_CREDIT_RX_ERR_EN`: `err_overflow` = 1 the next cycle and sticky until reset.
6. **Credit backlog and reset:**
   - Drain 4 words back-to-back → exactly 4 `credit_ret` pulses on consecutive cycles.
   - Assert `rst_n` = 0 mid-drain → all outputs at reset values; on release the initial 4-credit sequence repeats.
